// File: rtl/fifo_seq_control.sv
`default_nettype none
// ============================================================================
// Module      : fifo_seq_control
// Description : Sequences per-lane FIFO enables for a systolic-array load.
//               Supports a flat load (all lanes together) and a staggered
//               load where lane i lags lane 0 by i cycles. Provides abort,
//               a one-cycle done pulse and busy/weight_write status.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_seq_control #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int MAX_LEN      = 16,
  parameter int LEN_WIDTH    = $clog2(MAX_LEN + 1),
  parameter int CNT_WIDTH    = $clog2(MAX_LEN + WIDTH_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stagger_load,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic                    abort,
  output logic [WIDTH_HEIGHT-1:0] fifo_en,
  output logic                    busy,
  output logic                    weight_write,
  output logic                    done
);

  // One extra bit so lane-window and last-cycle arithmetic never overflows.
  localparam int CW = CNT_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] c_MAX_LEN = LEN_WIDTH'(MAX_LEN);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_count;
  logic [LEN_WIDTH-1:0]    r_len;
  logic                    r_stag;
  logic                    r_done;

  logic [LEN_WIDTH-1:0]    w_len_sat;
  logic [CW-1:0]           w_cnt_x;
  logic [CW-1:0]           w_len_x;
  logic [CW-1:0]           w_last;
  logic                    w_last_hit;
  logic [WIDTH_HEIGHT-1:0] w_en;

  // Requested length clamps to the deepest load the bank supports.
  assign w_len_sat = (len > c_MAX_LEN) ? c_MAX_LEN : len;

  assign w_cnt_x = CW'(r_count);
  assign w_len_x = CW'(r_len);

  // Staggered loads run until the last lane finishes its window.
  assign w_last     = r_stag ? (w_len_x + CW'(WIDTH_HEIGHT - 2)) : (w_len_x - CW'(1));
  assign w_last_hit = (w_cnt_x == w_last);

  // Each lane is enabled for a window of len_q cycles, offset by its index when staggered.
  for (genvar gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_lane
    localparam logic [CW-1:0] c_IDX = CW'(gi);
    assign w_en[gi] = r_stag ? ((w_cnt_x >= c_IDX) && (w_cnt_x < (c_IDX + w_len_x)))
                             : (w_cnt_x < w_len_x);
  end

  assign fifo_en      = (r_state == S_RUN) ? w_en : '0;
  assign busy         = (r_state == S_RUN);
  assign weight_write = (r_state == S_RUN);
  assign done         = r_done;

  // Load sequencer: accepts start in IDLE, counts through the run, pulses done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_len   <= '0;
      r_stag  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_state <= S_RUN;
              r_count <= '0;
              r_len   <= w_len_sat;
              r_stag  <= stagger_load;
            end else begin
              // Zero-length load completes immediately with no enables.
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (w_last_hit) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_seq_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_seq_control
// Description : Scoreboard bench for fifo_seq_control (WIDTH_HEIGHT=4,
//               MAX_LEN=8). Driver pushes hand-computed expected outputs;
//               a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_seq_control;

  localparam int WH  = 4;
  localparam int ML  = 8;
  localparam int LW  = $clog2(ML + 1);
  localparam int CNW = $clog2(ML + WH);

  logic          clk;
  logic          reset;
  logic          start;
  logic          stagger_load;
  logic [LW-1:0] len;
  logic          abort;
  logic [WH-1:0] fifo_en;
  logic          busy;
  logic          weight_write;
  logic          done;

  typedef struct packed {
    logic [WH-1:0] en;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  fifo_seq_control #(
    .WIDTH_HEIGHT(WH),
    .MAX_LEN     (ML)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stagger_load(stagger_load),
    .len         (len),
    .abort       (abort),
    .fifo_en     (fifo_en),
    .busy        (busy),
    .weight_write(weight_write),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge; queue what the outputs must be after the next rising edge.
  task automatic step(input string tag, input logic r, input logic s, input logic g,
                      input logic [LW-1:0] l, input logic a,
                      input logic [WH-1:0] e_en, input logic e_busy, input logic e_done);
    exp_t e;
    @(negedge clk);
    reset        = r;
    start        = s;
    stagger_load = g;
    len          = l;
    abort        = a;
    e.en   = e_en;
    e.busy = e_busy;
    e.done = e_done;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare outputs shortly after each rising edge against the scoreboard.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if ({fifo_en, busy, weight_write, done} !== {e.en, e.busy, e.busy, e.done}) begin
        bad++;
        $display("FAIL %s: got en=%b busy=%b ww=%b done=%b, want en=%b busy=%b ww=%b done=%b",
                 t, fifo_en, busy, weight_write, done, e.en, e.busy, e.busy, e.done);
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b1; stagger_load = 1'b0; len = LW'(3); abort = 1'b0;

    // Reset held with start asserted
    step("rst0", 0, 1, 0, 3, 0, 4'b0000, 0, 0);
    step("rst1", 0, 1, 0, 3, 0, 4'b0000, 0, 0);
    // Release: start accepted, flat len=3
    step("flat_c0", 1, 1, 0, 3, 0, 4'b1111, 1, 0);
    step("flat_c1", 1, 0, 0, 3, 0, 4'b1111, 1, 0);
    step("flat_c2", 1, 0, 0, 3, 0, 4'b1111, 1, 0);
    step("flat_done", 1, 0, 0, 3, 0, 4'b0000, 0, 1);
    step("flat_idle", 1, 0, 0, 3, 0, 4'b0000, 0, 0);

    // Stagger len=2
    step("stag_c0", 1, 1, 1, 2, 0, 4'b0001, 1, 0);
    step("stag_c1", 1, 0, 0, 0, 0, 4'b0011, 1, 0);
    step("stag_c2", 1, 0, 0, 0, 0, 4'b0110, 1, 0);
    step("stag_c3", 1, 0, 0, 0, 0, 4'b1100, 1, 0);
    step("stag_c4", 1, 0, 0, 0, 0, 4'b1000, 1, 0);
    step("stag_done", 1, 0, 0, 0, 0, 4'b0000, 0, 1);
    step("stag_idle", 1, 0, 0, 0, 0, 4'b0000, 0, 0);

    // len=0: immediate done, no enables
    step("len0_done", 1, 1, 0, 0, 0, 4'b0000, 0, 1);
    step("len0_idle", 1, 0, 0, 0, 0, 4'b0000, 0, 0);

    // len=15 saturates to 8
    step("sat_c0", 1, 1, 0, 15, 0, 4'b1111, 1, 0);
    for (int i = 1; i < 8; i++) step("sat_run", 1, 0, 0, 0, 0, 4'b1111, 1, 0);
    step("sat_done", 1, 0, 0, 0, 0, 4'b0000, 0, 1);
    step("sat_idle", 1, 0, 0, 0, 0, 4'b0000, 0, 0);

    // Abort at c=2 of stagger len=4
    step("ab_c0", 1, 1, 1, 4, 0, 4'b0001, 1, 0);
    step("ab_c1", 1, 0, 1, 4, 0, 4'b0011, 1, 0);
    step("ab_c2", 1, 0, 1, 4, 0, 4'b0111, 1, 0);
    step("ab_hit", 1, 0, 1, 4, 1, 4'b0000, 0, 0);
    step("ab_nodone", 1, 0, 1, 4, 0, 4'b0000, 0, 0);
    step("ab_idle", 1, 0, 1, 4, 0, 4'b0000, 0, 0);

    // Reset at c=2 of stagger len=4
    step("rr_c0", 1, 1, 1, 4, 0, 4'b0001, 1, 0);
    step("rr_c1", 1, 0, 1, 4, 0, 4'b0011, 1, 0);
    step("rr_c2", 1, 0, 1, 4, 0, 4'b0111, 1, 0);
    step("rr_hit", 0, 1, 1, 4, 0, 4'b0000, 0, 0);
    step("rr_nodone", 1, 0, 0, 4, 0, 4'b0000, 0, 0);
    step("idle_abort", 1, 0, 0, 4, 1, 4'b0000, 0, 0);
    // Cleared stag_q shows as flat enables on a new flat load
    step("rr_new_c0", 1, 1, 0, 1, 0, 4'b1111, 1, 0);
    step("rr_new_done", 1, 0, 0, 1, 0, 4'b0000, 0, 1);

    // Back-to-back: start in the done cycle of flat len=2
    step("bb1_c0", 1, 1, 0, 2, 0, 4'b1111, 1, 0);
    step("bb1_c1", 1, 0, 0, 2, 0, 4'b1111, 1, 0);
    step("bb1_done", 1, 0, 0, 2, 0, 4'b0000, 0, 1);
    step("bb2_c0", 1, 1, 0, 2, 0, 4'b1111, 1, 0);
    step("bb2_c1", 1, 0, 0, 2, 0, 4'b1111, 1, 0);
    step("bb2_done", 1, 0, 0, 2, 0, 4'b0000, 0, 1);
    step("bb2_idle", 1, 0, 0, 2, 0, 4'b0000, 0, 0);

    // Mid-run start with different len/stagger is ignored
    step("ig_c0", 1, 1, 0, 3, 0, 4'b1111, 1, 0);
    step("ig_c1", 1, 1, 1, 1, 0, 4'b1111, 1, 0);
    step("ig_c2", 1, 0, 1, 1, 0, 4'b1111, 1, 0);
    step("ig_done", 1, 0, 0, 1, 0, 4'b0000, 0, 1);
    step("ig_idle", 1, 0, 0, 1, 0, 4'b0000, 0, 0);

    // Start and abort together in IDLE: start wins
    step("sa_c0", 1, 1, 0, 2, 1, 4'b1111, 1, 0);
    step("sa_c1", 1, 0, 0, 2, 0, 4'b1111, 1, 0);
    step("sa_done", 1, 0, 0, 2, 0, 4'b0000, 0, 1);
    step("sa_idle", 1, 0, 0, 2, 0, 4'b0000, 0, 0);

    // Drain the scoreboard with a bounded wait
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      #5;
      if (exp_q.size() > 0) begin
        bad++;
        $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
